// File: rtl/dot_product_loader.sv
// rtl/dot_product_loader.sv - byte-stream loader and sequencer for the dot-product compute block
`timescale 1ns/1ps
module dot_product_loader #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_wr,
  output logic              calc_start,
  input  logic [ADDR_W-1:0] calc_mem_addr,
  input  logic              calc_done,
  input  logic [DATA_W-1:0] calc_result,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  input  logic              res_ready,
  output logic              busy
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {LOAD, START, COMPUTE, RESULT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [TO_W-1:0]   to_cnt;
  logic              in_load;

  assign in_load      = (state == LOAD);
  // Writes are combinational so the byte lands in memory on the edge it is accepted.
  assign in_ready     = in_load && !flush;
  assign mem_wr       = in_load && in_valid && !flush;
  assign mem_addr     = in_load ? wr_ptr : calc_mem_addr;
  assign mem_data_out = in_data;
  assign calc_start   = (state == START) && !flush;
  assign res_valid    = (state == RESULT);
  assign busy         = !in_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LOAD;
      wr_ptr   <= '0;
      to_cnt   <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else if (flush) begin
      state   <= LOAD;
      wr_ptr  <= '0;
      to_cnt  <= '0;
      res_err <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == LAST_ADDR) state <= START;
          end
        end
        START: begin
          to_cnt <= '0;
          state  <= COMPUTE;
        end
        COMPUTE: begin
          // A done seen while to_cnt is still zero may be left over from the previous run.
          if (calc_done && (to_cnt != '0)) begin
            res_data <= calc_result;
            res_err  <= 1'b0;
            to_cnt   <= '0;
            state    <= RESULT;
          end else if (to_cnt == TO_LAST) begin
            res_data <= '0;
            res_err  <= 1'b1;
            to_cnt   <= '0;
            state    <= RESULT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESULT: begin
          if (res_ready) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
